// File: rtl/ota_trim_pkg.sv
// ota_trim_pkg: shared definitions for the OTA trim loader.
//   - command byte encodings for the serial frame
//   - FSM state encoding
//   - frame length helper (8-bit command followed by W data bits)
package ota_trim_pkg;

  localparam int CMD_BITS  = 8;
  localparam int W_DEFAULT = 8;
  localparam int FRAME_BITS = CMD_BITS + W_DEFAULT;

  localparam logic [7:0] CMD_WR_SHADOW = 8'h01;
  localparam logic [7:0] CMD_WR_OE     = 8'h02;
  localparam logic [7:0] CMD_COMMIT    = 8'h03;
  localparam logic [7:0] CMD_CLR_ERR   = 8'h04;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    APPLY = 2'd2
  } state_e;

  // Total frame length in bits for a data field of width w.
  function automatic int frame_bits(input int w);
    return CMD_BITS + w;
  endfunction

endpackage

// File: rtl/ota_sync_edge.sv
// ota_sync_edge: multi-flop synchronizer for one asynchronous input, with
// rise/fall pulses derived against a one-flop delayed copy of the
// synchronized value.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   d          : asynchronous input
//   q          : synchronized level
//   rise, fall : one-cycle pulses on synchronized edges
// SYNC_STAGES must be at least 2. RST_VAL is the idle level of the input so
// that leaving reset never fabricates an edge.
module ota_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   q_d_r;

  // Synchronizer chain plus delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{RST_VAL}};
      q_d_r  <= RST_VAL;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d};
      q_d_r  <= sync_r[SYNC_STAGES-1];
    end
  end

  assign q    = sync_r[SYNC_STAGES-1];
  assign rise = sync_r[SYNC_STAGES-1] & ~q_d_r;
  assign fall = ~sync_r[SYNC_STAGES-1] & q_d_r;

endmodule

// File: rtl/ota_trim_loader.sv
// ota_trim_loader: serial configuration receiver for the OTA tile.
// A 3-wire frame (sclk, sdi, cs_n; MSB first, 8-bit cmd then W data bits)
// writes a shadow trim code, the pad output-enable mask, commits shadow to
// trim_out, or clears the sticky frame error.
// Ports:
//   clk, rst_n         : system clock, async active-low reset
//   ena                : block enable, low forces IDLE (registers hold)
//   sclk, sdi, cs_n    : asynchronous serial frame inputs
//   trim_out, trim_oe  : committed trim code and pad drive mask (1 = drive)
//   busy               : frame in progress
//   commit_pulse       : one-cycle pulse when trim_out is updated
//   frame_err          : sticky error (bad length or unknown cmd)
//   sdo                : readback data
// Optional feature macro: OTA_TRIM_READBACK_EN. When defined, sdo shifts out
// a snapshot of trim_out MSB-first during the data phase; otherwise sdo = 0.
module ota_trim_loader
  import ota_trim_pkg::*;
#(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         sclk,
  input  logic         sdi,
  input  logic         cs_n,
  output logic [W-1:0] trim_out,
  output logic [W-1:0] trim_oe,
  output logic         busy,
  output logic         commit_pulse,
  output logic         frame_err,
  output logic         sdo
);

  localparam int FRAME_LEN = frame_bits(W);
  localparam int CW        = $clog2(FRAME_LEN + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_LEN);
  localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_LEN + 1);

  logic sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s, sdi_q_s;
  logic sclk_q_unused_s, cs_q_unused_s, sdi_rise_unused_s, sdi_fall_unused_s;

  ota_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk),
    .q(sclk_q_unused_s), .rise(sclk_rise_s), .fall(sclk_fall_s));

  ota_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .clk(clk), .rst_n(rst_n), .d(sdi),
    .q(sdi_q_s), .rise(sdi_rise_unused_s), .fall(sdi_fall_unused_s));

  ota_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(cs_n),
    .q(cs_q_unused_s), .rise(cs_rise_s), .fall(cs_fall_s));

  state_e                 state_r, state_nxt_s;
  logic [CW-1:0]          cnt_r, cnt_nxt_s;
  logic [FRAME_LEN-1:0]   shift_r, shift_nxt_s;
  logic [W-1:0]           shadow_r, shadow_nxt_s;
  logic [W-1:0]           trim_out_r, trim_out_nxt_s;
  logic [W-1:0]           trim_oe_r, trim_oe_nxt_s;
  logic                   err_r, err_nxt_s, err_set_s, err_clr_s;
  logic                   commit_r, commit_nxt_s;
  logic                   busy_r;
  logic [7:0]             cmd_s;
  logic [W-1:0]           data_s;

  assign cmd_s  = shift_r[FRAME_LEN-1:W];
  assign data_s = shift_r[W-1:0];

  // Next-state, shift/count and command execution.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    shift_nxt_s    = shift_r;
    shadow_nxt_s   = shadow_r;
    trim_out_nxt_s = trim_out_r;
    trim_oe_nxt_s  = trim_oe_r;
    err_set_s      = 1'b0;
    err_clr_s      = 1'b0;
    commit_nxt_s   = 1'b0;
    if (!ena) begin
      state_nxt_s = IDLE;
      cnt_nxt_s   = '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cs_fall_s) begin
            state_nxt_s = SHIFT;
            cnt_nxt_s   = '0;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        SHIFT: begin
          // cs_n rise wins over a coincident sclk rise: that bit is dropped.
          if (cs_rise_s) begin
            if (cnt_r == CNT_FULL) begin
              state_nxt_s = APPLY;
            end else begin
              state_nxt_s = IDLE;
              err_set_s   = 1'b1;
            end
          end else if (sclk_rise_s) begin
            shift_nxt_s = {shift_r[FRAME_LEN-2:0], sdi_q_s};
            if (cnt_r != CNT_SAT) begin
              cnt_nxt_s = cnt_r + CW'(1);
            end else begin
              cnt_nxt_s = cnt_r;
            end
          end else begin
            state_nxt_s = SHIFT;
          end
        end
        APPLY: begin
          case (cmd_s)
            CMD_WR_SHADOW: shadow_nxt_s = data_s;
            CMD_WR_OE:     trim_oe_nxt_s = data_s;
            CMD_COMMIT: begin
              trim_out_nxt_s = shadow_r;
              commit_nxt_s   = 1'b1;
            end
            CMD_CLR_ERR:   err_clr_s = 1'b1;
            default:       err_set_s = 1'b1;
          endcase
          // A new frame starting during APPLY goes straight to SHIFT.
          if (cs_fall_s) begin
            state_nxt_s = SHIFT;
            cnt_nxt_s   = '0;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = '0;
        end
      endcase
    end
    // Setting the error wins over clearing it.
    if (err_set_s) begin
      err_nxt_s = 1'b1;
    end else if (err_clr_s) begin
      err_nxt_s = 1'b0;
    end else begin
      err_nxt_s = err_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      shift_r    <= '0;
      shadow_r   <= '0;
      trim_out_r <= '0;
      trim_oe_r  <= '0;
      err_r      <= 1'b0;
      commit_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      shift_r    <= shift_nxt_s;
      shadow_r   <= shadow_nxt_s;
      trim_out_r <= trim_out_nxt_s;
      trim_oe_r  <= trim_oe_nxt_s;
      err_r      <= err_nxt_s;
      commit_r   <= commit_nxt_s;
      busy_r     <= (state_nxt_s != IDLE);
    end
  end

  assign trim_out     = trim_out_r;
  assign trim_oe      = trim_oe_r;
  assign frame_err    = err_r;
  assign commit_pulse = commit_r;
  assign busy         = busy_r;

`ifdef OTA_TRIM_READBACK_EN
  localparam logic [CW-1:0] CNT_CMD_LAST = CW'(CMD_BITS - 1);
  localparam logic [CW-1:0] CNT_DATA0    = CW'(CMD_BITS);
  localparam logic [CW-1:0] CNT_DATA_END = CW'(FRAME_LEN - 1);

  logic [W-1:0] snap_r;
  logic         sdo_r;
  logic         snap_load_s;

  // Snapshot is taken as the last command bit is counted.
  assign snap_load_s = (state_nxt_s == SHIFT) && (cnt_r == CNT_CMD_LAST) &&
                       (cnt_nxt_s == CNT_DATA0);

  // Readback shifter: one trim_out bit per synchronized sclk fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_r <= '0;
      sdo_r  <= 1'b0;
    end else if (!ena || (state_r != SHIFT)) begin
      sdo_r <= 1'b0;
    end else if (snap_load_s) begin
      snap_r <= trim_out_r;
    end else if (sclk_fall_s) begin
      if ((cnt_r >= CNT_DATA0) && (cnt_r <= CNT_DATA_END)) begin
        sdo_r  <= snap_r[W-1];
        snap_r <= {snap_r[W-2:0], 1'b0};
      end else begin
        sdo_r <= 1'b0;
      end
    end
  end

  assign sdo = sdo_r;
`else
  logic unused_rb_s;
  assign unused_rb_s = sclk_fall_s;
  assign sdo = 1'b0;
`endif

endmodule

// File: tb/tb_ota_trim_loader.sv
// tb_ota_trim_loader: directed self-checking bench for ota_trim_loader.
// Serial frames are driven with 4-clk sclk phases; outputs are sampled on
// clk falling edges (or #1 after a rising edge for latency checks).
module tb_ota_trim_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       sclk = 1'b0;
  logic       sdi = 1'b0;
  logic       cs_n = 1'b1;
  logic [7:0] trim_out, trim_oe;
  logic       busy, commit_pulse, frame_err, sdo;

  int n_chk = 0;
  int n_fail = 0;
  int commit_cnt = 0;
  logic [31:0] rb_bits;

  ota_trim_loader #(.W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sclk(sclk), .sdi(sdi), .cs_n(cs_n),
    .trim_out(trim_out), .trim_oe(trim_oe), .busy(busy),
    .commit_pulse(commit_pulse), .frame_err(frame_err), .sdo(sdo));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (commit_pulse === 1'b1) commit_cnt <= commit_cnt + 1;
  end

  task automatic clock_bit(input logic b, input int idx);
    sdi = b;
    repeat (4) @(negedge clk);
    rb_bits[idx] = sdo;
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    sclk = 1'b0;
  endtask

  // Drops cs_n, shifts nbits of val (left aligned, MSB first) plus extra zero bits.
  task automatic shift_frame(input logic [15:0] val, input int nbits, input int extra);
    rb_bits = 32'h0;
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits + extra; i++) begin
      if (i < nbits) clock_bit(val[15-i], i);
      else clock_bit(1'b0, i);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] val, input int nbits, input int extra);
    shift_frame(val, nbits, extra);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({trim_out, trim_oe, busy, commit_pulse, frame_err, sdo} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_hold got %h required 00000", {trim_out, trim_oe, busy, commit_pulse, frame_err, sdo});
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_chk++;
    if ({trim_out, trim_oe, busy, commit_pulse, frame_err, sdo} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_release got %h required 00000", {trim_out, trim_oe, busy, commit_pulse, frame_err, sdo});
    end
  endtask

  task automatic test_commit;
    send_frame(16'h01A5, 16, 0);
    n_chk++;
    if (trim_out !== 8'h00) begin
      n_fail++;
      $display("FAIL shadow_not_committed got %h required 00", trim_out);
    end
    shift_frame(16'h0300, 16, 0);
    cs_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk);
      #1;
      if (e == 3) begin
        n_chk++;
        if (trim_out !== 8'h00 || commit_pulse !== 1'b0) begin
          n_fail++;
          $display("FAIL commit_early got out=%h pulse=%b required 00/0", trim_out, commit_pulse);
        end
      end else if (e == 4) begin
        n_chk++;
        if (trim_out !== 8'hA5 || commit_pulse !== 1'b1) begin
          n_fail++;
          $display("FAIL commit_edge4 got out=%h pulse=%b required a5/1", trim_out, commit_pulse);
        end
      end else if (e == 5) begin
        n_chk++;
        if (commit_pulse !== 1'b0) begin
          n_fail++;
          $display("FAIL commit_width got %b required 0", commit_pulse);
        end
      end
    end
    repeat (4) @(negedge clk);
    n_chk++;
    if (trim_oe !== 8'h00 || busy !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL commit_side got oe=%h busy=%b err=%b required 00/0/0", trim_oe, busy, frame_err);
    end
  endtask

  task automatic test_write_oe;
    int c0;
    c0 = commit_cnt;
    send_frame(16'h02F0, 16, 0);
    n_chk++;
    if (trim_oe !== 8'hF0 || trim_out !== 8'hA5 || commit_cnt != c0) begin
      n_fail++;
      $display("FAIL write_oe got oe=%h out=%h commits=%0d required f0/a5/0", trim_oe, trim_out, commit_cnt - c0);
    end
  endtask

  task automatic test_short_frame;
    send_frame(16'h01FE, 15, 0);
    n_chk++;
    if (frame_err !== 1'b1) begin
      n_fail++;
      $display("FAIL short_err got %b required 1", frame_err);
    end
    send_frame(16'h0300, 16, 0);
    n_chk++;
    if (trim_out !== 8'hA5) begin
      n_fail++;
      $display("FAIL short_shadow got %h required a5", trim_out);
    end
    send_frame(16'h0400, 16, 0);
    n_chk++;
    if (frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_err got %b required 0", frame_err);
    end
  endtask

  task automatic test_overrun_illegal;
    send_frame(16'h013C, 16, 3);
    n_chk++;
    if (frame_err !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_err got %b required 1", frame_err);
    end
    send_frame(16'h0755, 16, 0);
    n_chk++;
    if (frame_err !== 1'b1 || trim_oe !== 8'hF0 || trim_out !== 8'hA5) begin
      n_fail++;
      $display("FAIL illegal_cmd got err=%b oe=%h out=%h required 1/f0/a5", frame_err, trim_oe, trim_out);
    end
    send_frame(16'h0300, 16, 0);
    n_chk++;
    if (trim_out !== 8'hA5) begin
      n_fail++;
      $display("FAIL overrun_shadow got %h required a5", trim_out);
    end
  endtask

  task automatic test_ena_drop;
    send_frame(16'h0400, 16, 0);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 6; i++) clock_bit(1'b1, i);
    sdi = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ena_pre_busy got %b required 1", busy);
    end
    ena = 1'b0;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ena_drop got busy=%b err=%b required 0/0", busy, frame_err);
    end
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    sclk = 1'b0;
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    ena = 1'b1;
    repeat (4) @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || frame_err !== 1'b0 || trim_oe !== 8'hF0 || trim_out !== 8'hA5) begin
      n_fail++;
      $display("FAIL ena_hold got busy=%b err=%b oe=%h out=%h required 0/0/f0/a5", busy, frame_err, trim_oe, trim_out);
    end
    send_frame(16'h02FF, 16, 0);
    n_chk++;
    if (trim_oe !== 8'hFF) begin
      n_fail++;
      $display("FAIL ena_resume got %h required ff", trim_oe);
    end
  endtask

  task automatic test_reset_midframe;
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) clock_bit(1'b1, i);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (trim_oe !== 8'h00 || trim_out !== 8'h00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midframe got oe=%h out=%h busy=%b required 00/00/0", trim_oe, trim_out, busy);
    end
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int c0;
    c0 = commit_cnt;
    shift_frame(16'h013C, 16, 0);
    cs_n = 1'b1;
    @(negedge clk);
    shift_frame(16'h0300, 16, 0);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    n_chk++;
    if (trim_out !== 8'h3C || frame_err !== 1'b0 || commit_cnt != c0 + 1) begin
      n_fail++;
      $display("FAIL back_to_back got out=%h err=%b commits=%0d required 3c/0/1", trim_out, frame_err, commit_cnt - c0);
    end
  endtask

  task automatic test_readback;
    logic [7:0] got;
    send_frame(16'h0196, 16, 0);
    send_frame(16'h0300, 16, 0);
    send_frame(16'h0400, 16, 0);
    for (int i = 0; i < 8; i++) got[7-i] = rb_bits[8+i];
`ifdef OTA_TRIM_READBACK_EN
    n_chk++;
    if (got !== 8'h96 || rb_bits[7:0] !== 8'h00) begin
      n_fail++;
      $display("FAIL readback got data=%h cmd_phase=%h required 96/00", got, rb_bits[7:0]);
    end
`else
    n_chk++;
    if (rb_bits !== 32'h0) begin
      n_fail++;
      $display("FAIL sdo_tied got %h required 0", rb_bits);
    end
`endif
    n_chk++;
    if (trim_out !== 8'h96 || sdo !== 1'b0) begin
      n_fail++;
      $display("FAIL readback_end got out=%h sdo=%b required 96/0", trim_out, sdo);
    end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_write_oe();
    test_short_frame();
    test_overrun_illegal();
    test_ena_drop();
    test_reset_midframe();
    test_back_to_back();
    test_readback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
